// File: rtl/xbus_arb_if.sv
// Bundle of master-side request/response signals and the shared bus toward the decoder.
// The arbiter takes the slave modport; the requesters plus bus slaves take the master modport.
interface xbus_arb_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic              m0_err;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic              m1_err;
   logic [DATA_W-1:0] m1_rdata;

   logic              bus_sel;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_rdy;

   logic              busy;
   logic [1:0]        grant;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  bus_rdata, bus_rdy,
      output m0_ack, m0_err, m0_rdata,
      output m1_ack, m1_err, m1_rdata,
      output bus_sel, bus_we, bus_addr, bus_wdata,
      output busy, grant
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output bus_rdata, bus_rdy,
      input  m0_ack, m0_err, m0_rdata,
      input  m1_ack, m1_err, m1_rdata,
      input  bus_sel, bus_we, bus_addr, bus_wdata,
      input  busy, grant
   );
endinterface

// File: rtl/xbus_arb.sv
// Two-master round-robin bus arbiter: IDLE -> ACCESS -> RESP, grant held until bus_rdy
// or a bounded wait-state timeout. Every output is a register.
module xbus_arb #(
   parameter int ADDR_W  = 13,
   parameter int DATA_W  = 32,
   parameter int TO_W    = 4,
   parameter int TIMEOUT = 15
) (
   input logic      clk,
   input logic      rst,
   xbus_arb_if.slave xb
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT - 1);

   state_t            r_state;
   logic              r_last;
   logic              r_owner;
   logic [TO_W-1:0]   r_cnt;
   logic              r_sel;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_busy;
   logic [1:0]        r_grant;
   logic              r_m0_ack;
   logic              r_m0_err;
   logic [DATA_W-1:0] r_m0_rdata;
   logic              r_m1_ack;
   logic              r_m1_err;
   logic [DATA_W-1:0] r_m1_rdata;

   logic              w_any;
   logic              w_pick;
   logic              w_done;
   logic              w_to;
   logic [DATA_W-1:0] w_rdata;

   // On a tie the master that was not served last wins (r_last=1 means m1).
   always_comb begin
      w_any   = xb.m0_req | xb.m1_req;
      w_pick  = (xb.m0_req & xb.m1_req) ? ~r_last : xb.m1_req;
      w_done  = xb.bus_rdy | (r_cnt == LP_TO_LAST);
      w_to    = ~xb.bus_rdy;
      w_rdata = (xb.bus_rdy & ~r_we) ? xb.bus_rdata : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_last     <= 1'b1;
         r_owner    <= 1'b0;
         r_cnt      <= '0;
         r_sel      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
         r_grant    <= 2'b00;
         r_m0_ack   <= 1'b0;
         r_m0_err   <= 1'b0;
         r_m0_rdata <= '0;
         r_m1_ack   <= 1'b0;
         r_m1_err   <= 1'b0;
         r_m1_rdata <= '0;
      end else begin
         r_m0_ack <= 1'b0;
         r_m0_err <= 1'b0;
         r_m1_ack <= 1'b0;
         r_m1_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner <= w_pick;
                  r_grant <= w_pick ? 2'b10 : 2'b01;
                  r_we    <= w_pick ? xb.m1_we    : xb.m0_we;
                  r_addr  <= w_pick ? xb.m1_addr  : xb.m0_addr;
                  r_wdata <= w_pick ? xb.m1_wdata : xb.m0_wdata;
                  r_cnt   <= '0;
                  r_sel   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // bus_rdy takes priority over a timeout landing in the same cycle.
               if (w_done) begin
                  r_sel   <= 1'b0;
                  r_grant <= 2'b00;
                  r_state <= S_RESP;
                  if (r_owner) begin
                     r_m1_ack   <= 1'b1;
                     r_m1_err   <= w_to;
                     r_m1_rdata <= w_rdata;
                  end else begin
                     r_m0_ack   <= 1'b1;
                     r_m0_err   <= w_to;
                     r_m0_rdata <= w_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               r_last  <= r_owner;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign xb.m0_ack    = r_m0_ack;
   assign xb.m0_err    = r_m0_err;
   assign xb.m0_rdata  = r_m0_rdata;
   assign xb.m1_ack    = r_m1_ack;
   assign xb.m1_err    = r_m1_err;
   assign xb.m1_rdata  = r_m1_rdata;
   assign xb.bus_sel   = r_sel;
   assign xb.bus_we    = r_we;
   assign xb.bus_addr  = r_addr;
   assign xb.bus_wdata = r_wdata;
   assign xb.busy      = r_busy;
   assign xb.grant     = r_grant;

endmodule

// File: doc/xbus_arb.md
# xbus_arb

Two-master arbiter and sequencer for the shared data bus: the processor controller (master 0) and a secondary requester such as a DMA or debug port (master 1). It drives the bus that feeds the address decoder and slaves. It grants one master at a time with round-robin fairness and holds the grant until the addressed slave signals ready. A bounded wait-state timeout ends any access whose slave never responds.

## Interface
- ADDR_W, 13, data bus address width
- DATA_W, 32, data word width
- TO_W, 4, timeout counter width
- TIMEOUT, 15, maximum ACCESS cycles without bus_rdy before forced termination (1..2^TO_W-1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req, m1_req  in  1  access request; held with attributes until own ack
- m0_we, m1_we  in  1  1=write, 0=read
- m0_addr, m1_addr  in  ADDR_W  access address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  valid with ack; 1=timed out
- m0_rdata, m1_rdata  out  DATA_W  read data, valid with ack
- bus_sel  out  1  bus select toward decoder
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_rdata  in  DATA_W  read data from decoder mux
- bus_rdy  in  1  slave completion, sampled only while bus_sel=1
- busy  out  1  1 when not IDLE
- grant  out  2  one-hot current owner ({m1,m0}); 00 in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the master other than last_served. On grant, latch we/addr/wdata into bus registers, clear timeout counter, set grant, go to ACCESS.
- ACCESS: bus_sel=1 with latched attributes. Each cycle:
  - If bus_rdy=1: capture bus_rdata (reads; 0 for writes), err=0, go to RESP.
  - Else if counter==TIMEOUT-1: capture rdata=0, err=1, go to RESP.
  - Else counter+1.
  - bus_rdy wins over a simultaneous timeout.
- RESP: bus_sel=0. Owner's ack=1 with its rdata/err. last_served=owner, grant cleared, go to IDLE.
- Non-owner ack/err stay 0. Non-owner rdata holds its last value.
- Changes to master inputs after grant are ignored until the next IDLE.
- A master must drop req in the cycle after ack. A req still high in IDLE is a new request.
- Counter saturates and never wraps within an access. It is cleared on every grant.
- Reset: state=IDLE, last_served=m1 (so m0 wins the first tie). All outputs 0, all registers 0.
- Reset asserted mid-access aborts immediately. No ack is issued, and the bus drops on reset assertion.

## Timing
- All outputs are registered. None depend combinationally on inputs.
- req high in cycle 0 leads to bus_sel=1 in cycle 1.
- bus_rdy in cycle 1+k (k wait states) leads to ack in cycle 2+k.
- Minimum request-to-ack latency is 2 cycles. Back-to-back throughput is 1 access per 3 cycles (IDLE, ACCESS, RESP).
- A timed-out access has bus_sel high for exactly TIMEOUT cycles, and ack/err arrive the following cycle.
- busy=1 in ACCESS and RESP. grant is held through ACCESS and cleared on entry to RESP.

## Test plan
- Single m0 read at addr 0x010, bus_rdy=1 in first ACCESS cycle, bus_rdata=0xDEADBEEF -> bus_sel high 1 cycle, m0_ack and m0_rdata=0xDEADBEEF 2 cycles after req, m0_err=0, m1_ack=0.
- m0 and m1 request together from reset, each bus_rdy immediate -> m0 served first, m1 next, then m0 again if m0 re-requests (strict alternation, grant one-hot).
- m1 write addr 0x1FFF data 0x12345678, bus_rdy after 3 wait states -> bus_we=1, bus_addr/bus_wdata stable 4 cycles, m1_ack 5 cycles after req, m1_rdata=0.
- bus_rdy never asserted, TIMEOUT=15 -> bus_sel high exactly 15 cycles, then m0_ack=1, m0_err=1, m0_rdata=0, FSM back to IDLE.
- bus_rdy asserted in the same cycle the counter reaches TIMEOUT-1 -> err=0, rdata captured.
- rst driven low during ACCESS with 2 wait states elapsed -> all outputs 0 asynchronously, no ack. After release, a pending m1 req with m0 idle is granted on the next edge.
